// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// Purpose : memory-side responder for the controller's byte-serial RAM port (RAM + UART I/O window).
// Latency : read data registered, visible one cycle after the address; TX push/pop and rx_pop act at that same edge.
// Backpressure: uart_full asserts with two TX entries still free; a push into a full FIFO without a pop is dropped and flagged sticky.
//
// Ports:
//   clk, rst (async active-low), rdy (global enable, freezes all state when low)
//   wr_flag/addr/data_i : access presented by the controller every cycle, no strobe
//   data_o              : registered read byte
//   uart_full           : stall request to the controller
//   tx_data/tx_valid/tx_ready : TX FIFO head towards the UART transmitter
//   rx_data/rx_valid/rx_pop   : UART receive byte and its consume pulse
//   tx_overflow         : sticky, a TX write was dropped
module mem_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int IO_SEL_BIT    = 17,
    parameter int TX_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        wr_flag,
    input  logic [31:0] addr,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        uart_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        tx_overflow
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] FULL_MARK = CNT_W'(TX_DEPTH - 2);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                     io_sel;
    logic [2:0]               io_off;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic                     unused_addr_hi;

    assign io_sel  = addr[IO_SEL_BIT];
    assign io_off  = addr[2:0];
    assign ram_idx = addr[RAM_ADDR_BITS-1:0];
    // Upper address bits are don't-care; the controller may leave them set.
    assign unused_addr_hi = ^addr[31:IO_SEL_BIT+1];

    logic ram_we;
    logic tx_push_req;
    logic rx_rd;

    assign ram_we      = rdy & ~io_sel & wr_flag;
    assign tx_push_req = rdy &  io_sel & wr_flag  & (io_off == 3'd0);
    assign rx_rd       = rdy &  io_sel & ~wr_flag & (io_off == 3'd0);

    // Consume pulse coincides with the edge that captures rx_data into data_o,
    // so the UART can advance to its next byte on that same edge.
    assign rx_pop = rx_rd & rx_valid;

    // ------------------------------------------------------------------
    // RAM array (contents survive reset)
    // ------------------------------------------------------------------
    logic [7:0] ram_q [2**RAM_ADDR_BITS];
    logic [7:0] ram_rd;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= data_i;
        end
    end

    assign ram_rd = ram_q[ram_idx];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             tx_pop;
    logic             tx_push;

    assign tx_valid = (count_q != '0);
    assign tx_data  = tx_mem_q[rd_ptr_q];
    assign tx_pop   = rdy & tx_valid & tx_ready;
    // A same-cycle pop frees the head slot, so a full FIFO still takes the push.
    assign tx_push  = tx_push_req & ((count_q < DEPTH_C) | tx_pop);

    assign uart_full   = (count_q >= FULL_MARK);
    assign tx_overflow = tx_ovf_q;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        tx_ovf_d = tx_ovf_q;

        // Pointer widths equal log2(TX_DEPTH), so increment wraps by itself.
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (tx_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({tx_push, tx_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (tx_push_req && !tx_push) begin
            tx_ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read data register
    // ------------------------------------------------------------------
    logic [7:0] data_q, data_d;

    // Writes leave data_o untouched; only reads load a new byte.
    always_comb begin
        data_d = data_q;
        if (rdy && !wr_flag) begin
            if (!io_sel) begin
                data_d = ram_rd;
            end else begin
                case (io_off)
                    3'd0:    data_d = rx_valid ? rx_data : 8'h00;
                    3'd4:    data_d = {6'b0, rx_valid, tx_valid};
                    default: data_d = 8'h00;
                endcase
            end
        end
    end

    assign data_o = data_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= 8'h00;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

endmodule
